midi_note_parser: RTL

Byte-level MIDI channel-voice parser that converts the serial MIDI byte stream from the UART receiver into a monophonic note index, velocity and gate. Its `noteIdx` output drives the address input of the note-to-wavetable index ROM; its gate and velocity feed the envelope generator. It tracks running status, ignores messages it does not use, and is transparent to real-time bytes.

---
 rtl/midi_note_parser.sv | 107 ++++++++++
 1 files changed

// File: rtl/midi_note_parser.sv
// midi_note_parser: byte-level MIDI channel-voice parser producing a
// monophonic note index, velocity and gate with last-note priority.
// Tracks running status, skips SysEx and unused messages, and ignores
// real-time bytes wherever they appear.
module midi_note_parser #(
    parameter int   CHANNEL = 0,
    parameter logic OMNI    = 1'b0,
    parameter int   A_WIDTH = 7
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [7:0]         rxData,
    input  logic               rxValid,
    output logic [A_WIDTH-1:0] noteIdx,
    output logic [6:0]         velocity,
    output logic               gate,
    output logic               noteEvt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_D1,
        S_WAIT_D2,
        S_SYSEX
    } state_t;

    localparam logic [3:0] L_CHAN = CHANNEL[3:0];

    state_t     r_state;
    logic [7:0] r_status;   // running status, 0 when cleared
    logic [6:0] r_d1;

    logic       w_realtime;
    logic       w_status;
    logic       w_data;
    logic       w_chan_status;
    logic       w_one_byte;
    logic       w_match;
    logic [3:0] w_type;
    logic       w_done2;
    logic       w_note_on;
    logic       w_note_off;

    assign w_realtime    = rxValid && (rxData[7:3] == 5'b11111);
    assign w_status      = rxValid && rxData[7] && !w_realtime;
    assign w_data        = rxValid && !rxData[7];
    assign w_chan_status = rxData[7:4] != 4'hF;
    assign w_type        = r_status[7:4];
    // Program change (0xC) and channel pressure (0xD) carry one data byte
    assign w_one_byte    = (w_type == 4'hC) || (w_type == 4'hD);
    assign w_match       = OMNI || (r_status[3:0] == L_CHAN);

    // Only two-byte messages can touch the note outputs, so a completion
    // in WAIT_D1 (single-byte message) never needs decoding here.
    assign w_done2    = w_data && (r_state == S_WAIT_D2) && w_match;
    assign w_note_on  = w_done2 && (w_type == 4'h9) && (rxData[6:0] != 7'd0);
    assign w_note_off = w_done2 && gate && (A_WIDTH'(r_d1) == noteIdx) &&
                        ((w_type == 4'h8) ||
                         ((w_type == 4'h9) && (rxData[6:0] == 7'd0)));

    // Parser FSM with registered note outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_status <= 8'h00;
            r_d1     <= 7'd0;
            noteIdx  <= '0;
            velocity <= 7'd0;
            gate     <= 1'b0;
            noteEvt  <= 1'b0;
        end else begin
            noteEvt <= 1'b0;
            if (w_status) begin
                // Any status byte, in any state, starts over; a partial
                // message in WAIT_D2 is simply dropped.
                if (w_chan_status) begin
                    r_status <= rxData;
                    r_state  <= S_WAIT_D1;
                end else begin
                    r_status <= 8'h00;
                    r_state  <= (rxData == 8'hF0) ? S_SYSEX : S_IDLE;
                end
            end else if (w_data) begin
                case (r_state)
                    S_WAIT_D1: begin
                        r_d1    <= rxData[6:0];
                        r_state <= w_one_byte ? S_WAIT_D1 : S_WAIT_D2;
                    end
                    S_WAIT_D2: begin
                        r_state <= S_WAIT_D1;
                        if (w_note_on) begin
                            noteIdx  <= A_WIDTH'(r_d1);
                            velocity <= rxData[6:0];
                            gate     <= 1'b1;
                            noteEvt  <= 1'b1;
                        end else if (w_note_off) begin
                            gate    <= 1'b0;
                            noteEvt <= 1'b1;
                        end
                    end
                    default: r_state <= r_state;   // IDLE / SYSEX discard data
                endcase
            end
        end
    end

endmodule
